// File: rtl/seg_pipe_adder_pkg.sv
// Shared configuration helpers for the segmented pipelined adder:
// stage count, geometry check and the result reset value.
package seg_pipe_adder_pkg;

   localparam logic RESULT_RESET_BIT = 1'b0;

   function automatic int calc_stages(input int width, input int seg);
      return width / seg;
   endfunction

   function automatic bit seg_cfg_ok(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/seg_add_stage.sv
// Combinational SEG-bit ripple-carry segment. It also exposes the carry into
// its MSB so the top segment can form two's-complement overflow.
module seg_add_stage
   import seg_pipe_adder_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           c_msb
);

   logic [SEG:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < SEG; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c[SEG];
   assign c_msb = c[SEG-1];

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined add/subtract unit: one SEG-bit ripple segment per stage, with a
// global-stall valid/ready handshake around the whole pipe.
module seg_pipe_adder
   import seg_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_c,
   output logic             out_v
);

   localparam int STAGES = calc_stages(WIDTH, SEG);

   if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG");
   end

   logic             adv;
   logic [WIDTH-1:0] eff_b;
   logic             eff_cin;
   logic             ovf_q;

   // Subtraction is A + ~B + 1, so the caller's carry-in is overridden.
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;
   assign eff_b    = in_sub ? ~in_b : in_b;
   assign eff_cin  = in_sub | in_cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int OPW  = (STAGES - k) * SEG;
      localparam int SUMW = (k + 1) * SEG;

      logic [OPW-1:0]  a_op;
      logic [OPW-1:0]  b_op;
      logic            c_in;
      logic            v_in;
      logic [SUMW-1:0] sum_d;
      logic [SEG-1:0]  s;
      logic            c_out;
      logic            c_msb;
      logic            v_q;
      logic            c_q;
      logic [SUMW-1:0] sum_q;

      if (k == 0) begin : g_head
         assign a_op  = in_a;
         assign b_op  = eff_b;
         assign c_in  = eff_cin;
         assign v_in  = in_valid;
         assign sum_d = s;
      end else begin : g_body
         // Skew registers carry only the not-yet-consumed upper segments.
         always_ff @(posedge clk) begin
            if (adv) begin
               a_op <= g_stg[k-1].a_op[OPW+SEG-1:SEG];
               b_op <= g_stg[k-1].b_op[OPW+SEG-1:SEG];
            end
         end

         assign c_in  = g_stg[k-1].c_q;
         assign v_in  = g_stg[k-1].v_q;
         assign sum_d = {s, g_stg[k-1].sum_q};
      end

      seg_add_stage #(.SEG(SEG)) u_add (
         .a     (a_op[SEG-1:0]),
         .b     (b_op[SEG-1:0]),
         .cin   (c_in),
         .sum   (s),
         .cout  (c_out),
         .c_msb (c_msb)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q   <= 1'b0;
            c_q   <= RESULT_RESET_BIT;
            sum_q <= {SUMW{RESULT_RESET_BIT}};
         end else if (adv) begin
            v_q   <= v_in;
            c_q   <= c_out;
            sum_q <= sum_d;
         end
      end

      if (k == STAGES - 1) begin : g_tail
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= RESULT_RESET_BIT;
            end else if (adv) begin
               ovf_q <= c_msb ^ c_out;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_q;
   assign out_sum   = g_stg[STAGES-1].sum_q;
   assign out_c     = g_stg[STAGES-1].c_q;
   assign out_v     = ovf_q;

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
Parametrised pipelined add/subtract unit. It is the successor to the single-cycle ripple adder. The WIDTH-bit operation is split into SEG-bit ripple segments, one segment per pipeline stage, so the carry chain per cycle is SEG bits long. It adds carry-in, subtract mode, signed overflow and a valid/ready handshake with backpressure, for use in datapaths that need more than 4 bits at full clock rate.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, and STAGES must be at least 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat present.
in_ready  out  1  unit accepts beat this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_cin  in  1  carry-in; ignored when in_sub=1.
in_sub  in  1  0 = A+B+cin, 1 = A-B.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result.
out_sum  out  WIDTH  result bits.
out_c  out  1  carry-out of MSB. In subtract mode this is NOT-borrow: 1 when A >= B unsigned.
out_v  out  1  two's-complement overflow.

Behaviour:
- Reset is asynchronous and active-high: rst=1 clears all stage valid bits, out_valid, out_sum, out_c and out_v to 0 immediately. This is independent of clk.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Advance enable: adv = !out_valid | out_ready.
  - in_ready = adv, combinational.
  - All stages shift together when adv=1 and hold completely when adv=0, i.e. a global stall.
- Bubbles propagate as valid=0 stages. A stage with valid=0 still shifts but its data is don't-care.
- Operand preprocessing at accept:
  - Effective B = in_sub ? ~in_b : in_b.
  - Effective carry-in = in_sub ? 1 : in_cin.
- Stage k (0..STAGES-1):
  - Adds segment k of A and effective B plus the carry registered by stage k-1; stage 0 uses the effective carry-in.
  - Registers the SEG-bit partial sum and the segment carry-out.
  - Unconsumed upper operand segments travel forward in skew registers.
  - Completed lower sum segments travel forward in de-skew registers.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles after acceptance when there is no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- out_c is the carry-out of the top segment.
- out_v = carry into MSB XOR carry out of MSB. The last stage computes this internally from its bit-level carries.
- Results are held stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in the same cycle is allowed; there are no lost or duplicated beats and order is preserved.
- STAGES=1 degenerates to a registered single-stage adder with the same handshake.
- Reset mid-operation discards all in-flight beats. After deassertion the first accepted beat emerges STAGES cycles later.

Decomposition:
- Shared package: a function for STAGES = WIDTH/SEG, an elaboration-time check that WIDTH % SEG == 0, and a localparam for the reset value of the result (all zeros).
- Sub-module seg_add_stage (parameter SEG):
  - Combinational SEG-bit ripple of full adders with carry-in.
  - Outputs the segment sum, carry-out, and carry into the segment MSB (used for out_v).
  - Instantiated STAGES times via generate.
  - Pipeline registers stay in seg_pipe_adder.

Test Plan (WIDTH=16, SEG=4, latency 4):
1. Accept A=0xFFFF, B=0x0001, cin=0, sub=0 with out_ready=1 -> 4 cycles later: out_valid=1, sum=0x0000, c=1, v=0.
2. A=0x7FFF, B=0x0001, add -> sum=0x8000, c=0, v=1. Then A=0x00FF, B=0x0000, cin=1 -> sum=0x0100, c=0, v=0, on the next cycle.
3. Subtract cases:
   - A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, c=0, v=0.
   - A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, c=1, v=1.
4. Eight back-to-back beats (A=i, B=0x1000·i) with out_ready held low for 3 cycles after the first result:
   - in_ready is low for those cycles.
   - out_sum is stable throughout.
   - All 8 results arrive in order with no gaps beyond the stall.
5. Sparse input (in_valid on alternate cycles) with random out_ready -> every accepted beat matches the reference model A+B+cin or A-B, in order.
6. Assert rst asynchronously, mid-cycle, with 3 beats in flight -> out_valid drops immediately with no clk edge required, and no stale results appear after release. A new beat then emerges exactly 4 cycles after its acceptance.
